instr_prefetch_queue: RTL

Fetch stage between the instruction memory and the pipelined processor's decode stage. It issues sequential 16-bit instruction fetches over a req/ack memory interface that may take several cycles to answer, with one request outstanding at a time. Fetched words are buffered in a small FIFO together with their PC and handed to decode through a valid/ready handshake. A branch or jump redirect flushes the queue and restarts fetching at the target.

---
 rtl/instr_prefetch_queue_pkg.sv | 22 ++
 rtl/prefetch_fifo.sv | 89 ++++++++
 rtl/instr_prefetch_queue.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/instr_prefetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Package  : instr_prefetch_queue_pkg
// Summary  : Shared widths, reset defaults and fetch FSM encoding for the
//            instruction prefetch queue.
// Revision : 1.0 - initial release
// ============================================================================
package instr_prefetch_queue_pkg;

    localparam int unsigned     C_PC_W      = 16;
    localparam int unsigned     C_INSTR_W   = 16;
    localparam logic [15:0]     C_RESET_PC  = 16'h0000;
    localparam int unsigned     C_PC_STEP   = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/prefetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : prefetch_fifo
// Summary  : Synchronous FIFO of {pc, instr} entries; flush beats push/pop.
// Revision : 1.0 - initial release
// ============================================================================
module prefetch_fifo
    import instr_prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned PC_W    = C_PC_W,
    parameter int unsigned INSTR_W = C_INSTR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [PC_W-1:0]        i_push_pc,
    input  logic [INSTR_W-1:0]     i_push_instr,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [PC_W-1:0]        o_head_pc,
    output logic [INSTR_W-1:0]     o_head_instr,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned        C_PTR_W   = $clog2(DEPTH);
    localparam logic [C_PTR_W-1:0] C_PTR_ONE = C_PTR_W'(1);
    localparam logic [C_PTR_W:0]   C_CNT_ONE = (C_PTR_W + 1)'(1);

    logic [PC_W-1:0]    r_pc_mem_q    [DEPTH];
    logic [INSTR_W-1:0] r_instr_mem_q [DEPTH];
    logic [C_PTR_W-1:0] r_head_q;
    logic [C_PTR_W-1:0] w_head_d;
    logic [C_PTR_W-1:0] r_tail_q;
    logic [C_PTR_W-1:0] w_tail_d;
    logic [C_PTR_W:0]   r_count_q;
    logic [C_PTR_W:0]   w_count_d;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign w_push_ok = i_push && !i_flush;
    assign w_pop_ok  = i_pop && !i_flush && (r_count_q != '0);

    always_comb begin
        w_head_d  = r_head_q;
        w_tail_d  = r_tail_q;
        w_count_d = r_count_q;
        if (i_flush) begin
            w_head_d  = '0;
            w_tail_d  = '0;
            w_count_d = '0;
        end else begin
            if (w_push_ok) begin
                w_tail_d  = r_tail_q + C_PTR_ONE;
                w_count_d = w_count_d + C_CNT_ONE;
            end
            if (w_pop_ok) begin
                w_head_d  = r_head_q + C_PTR_ONE;
                w_count_d = w_count_d - C_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_q  <= '0;
            r_tail_q  <= '0;
            r_count_q <= '0;
        end else begin
            r_head_q  <= w_head_d;
            r_tail_q  <= w_tail_d;
            r_count_q <= w_count_d;
        end
    end

    // Storage needs no reset: entries are only visible through a nonzero count.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_pc_mem_q[r_tail_q]    <= i_push_pc;
            r_instr_mem_q[r_tail_q] <= i_push_instr;
        end
    end

    assign o_head_pc    = r_pc_mem_q[r_head_q];
    assign o_head_instr = r_instr_mem_q[r_head_q];
    assign o_count      = r_count_q;

endmodule
`default_nettype wire

// File: rtl/instr_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_prefetch_queue
// Summary  : Sequential instruction fetcher with one outstanding req/ack
//            request, a small {pc, instr} queue and redirect flush.
// Revision : 1.0 - initial release
// ============================================================================
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter int unsigned      DEPTH    = 4,
    parameter int unsigned      PC_W     = C_PC_W,
    parameter int unsigned      INSTR_W  = C_INSTR_W,
    parameter logic [PC_W-1:0]  RESET_PC = C_RESET_PC,
    parameter int unsigned      PC_STEP  = C_PC_STEP
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   mem_req,
    output logic [PC_W-1:0]        mem_addr,
    input  logic                   mem_ack,
    input  logic [INSTR_W-1:0]     mem_rdata,
    output logic                   dec_valid,
    output logic [INSTR_W-1:0]     dec_instr,
    output logic [PC_W-1:0]        dec_pc,
    input  logic                   dec_ready,
    input  logic                   redirect,
    input  logic [PC_W-1:0]        redirect_pc,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int unsigned        C_CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [C_CNT_W-1:0] C_CNT_ONE   = C_CNT_W'(1);
    localparam logic [C_CNT_W-1:0] C_DEPTH_CNT = C_CNT_W'(DEPTH);
    localparam logic [PC_W-1:0]    C_STEP      = PC_W'(PC_STEP);

    fetch_state_e       r_state_q;
    fetch_state_e       w_state_d;
    logic [PC_W-1:0]    r_fetch_pc_q;
    logic [PC_W-1:0]    w_fetch_pc_d;
    logic [PC_W-1:0]    r_mem_addr_q;
    logic [PC_W-1:0]    w_mem_addr_d;
    logic [PC_W-1:0]    w_fetch_pc_inc;
    logic [C_CNT_W-1:0] w_count;
    logic [C_CNT_W-1:0] w_count_next;
    logic               w_push;
    logic               w_pop;
    logic               w_has_room;

    // Redirect suppresses both queue updates; the FIFO flush covers the rest.
    assign w_push         = (r_state_q == ST_WAIT) && mem_ack && !redirect;
    assign w_pop          = (w_count != '0) && dec_ready && !redirect;
    assign w_fetch_pc_inc = r_fetch_pc_q + C_STEP;
    assign w_has_room     = (w_count_next < C_DEPTH_CNT);

    always_comb begin
        w_count_next = w_count;
        if (w_push) begin
            w_count_next = w_count_next + C_CNT_ONE;
        end
        if (w_pop) begin
            w_count_next = w_count_next - C_CNT_ONE;
        end
    end

    always_comb begin
        w_state_d    = r_state_q;
        w_fetch_pc_d = r_fetch_pc_q;
        w_mem_addr_d = r_mem_addr_q;
        if (redirect) begin
            w_fetch_pc_d = redirect_pc;
            // An unanswered request must still be acknowledged before reissue.
            case (r_state_q)
                ST_WAIT:    w_state_d = mem_ack ? ST_IDLE : ST_DISCARD;
                ST_DISCARD: w_state_d = mem_ack ? ST_IDLE : ST_DISCARD;
                default:    w_state_d = ST_IDLE;
            endcase
        end else begin
            case (r_state_q)
                ST_IDLE: begin
                    if (w_has_room) begin
                        w_mem_addr_d = r_fetch_pc_q;
                        w_state_d    = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_ack) begin
                        w_fetch_pc_d = w_fetch_pc_inc;
                        if (w_has_room) begin
                            w_mem_addr_d = w_fetch_pc_inc;
                        end else begin
                            w_state_d = ST_IDLE;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (mem_ack) begin
                        w_state_d = ST_IDLE;
                    end
                end
                default: w_state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= ST_IDLE;
            r_fetch_pc_q <= RESET_PC;
            r_mem_addr_q <= RESET_PC;
        end else begin
            r_state_q    <= w_state_d;
            r_fetch_pc_q <= w_fetch_pc_d;
            r_mem_addr_q <= w_mem_addr_d;
        end
    end

    prefetch_fifo #(
        .DEPTH   (DEPTH),
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_push_pc    (r_fetch_pc_q),
        .i_push_instr (mem_rdata),
        .i_pop        (w_pop),
        .i_flush      (redirect),
        .o_head_pc    (dec_pc),
        .o_head_instr (dec_instr),
        .o_count      (w_count)
    );

    assign mem_req   = (r_state_q != ST_IDLE);
    assign mem_addr  = r_mem_addr_q;
    assign dec_valid = (w_count != '0);
    assign occupancy = w_count;

endmodule
`default_nettype wire
